// File: rtl/neuron_argmax.sv
// ============================================================================
// Module   : neuron_argmax
// Purpose  : Running-argmax over N_CLASSES serialised neuron scores with a
//            valid/ack result handshake. Optional macro: ARGMAX_RELU_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module neuron_argmax #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 26,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              In_valid,
    input  logic [DATA_W-1:0] In_data,
    output logic              In_ready,
    output logic              Result_valid,
    input  logic              Result_ack,
    output logic [IDX_W-1:0]  Class_idx,
    output logic [DATA_W-1:0] Max_score,
    output logic [IDX_W-1:0]  Score_cnt
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    cnt;
    logic [DATA_W-1:0]   best;
    logic [IDX_W-1:0]    best_idx;

    logic                accept;
    logic                is_last;
    logic                take_score;
    logic [DATA_W-1:0]   score;

`ifdef ARGMAX_RELU_EN
    // Negative scores become zero before both compare and storage.
    assign score = In_data[DATA_W-1] ? '0 : In_data;
`else
    assign score = In_data;
`endif

    assign accept     = In_valid && (state == COLLECT);
    assign is_last    = (cnt == LAST_IDX);
    // Strict greater-than keeps the lowest index on ties.
    assign take_score = (cnt == '0) || ($signed(score) > $signed(best));

    always_comb begin
        state_next   = state;
        In_ready     = 1'b0;
        Result_valid = 1'b0;
        case (state)
            COLLECT: begin
                In_ready = 1'b1;
                if (accept && is_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Result_valid = 1'b1;
                if (Result_ack) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            cnt      <= '0;
            best     <= '0;
            best_idx <= '0;
        end else if (accept) begin
            cnt <= is_last ? '0 : cnt + 1'b1;
            if (take_score) begin
                best     <= score;
                best_idx <= cnt;
            end
        end
    end

    assign Class_idx = best_idx;
    assign Max_score = best;
    assign Score_cnt = cnt;

endmodule

`default_nettype wire
